// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder
//   Responder side of the 64-bit physical-memory line interface. It takes one
//   line request at a time (read or write, 32-byte aligned) and waits LATENCY
//   cycles from acceptance to the first beat. It then transfers BURST_LEN 64-bit
//   beats with pmem_resp high for each one. Data is held in an internal word
//   array that reset does not clear.
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   pmem_read     line read request, held until the last beat
//   pmem_write    line write request, held until the last beat
//   pmem_address  line address; [4:0] and bits above DEPTH_BITS+2 ignored
//   pmem_wdata    write beat k, presented during the k-th resp cycle
//   pmem_resp     high for BURST_LEN consecutive cycles per accepted request
//   pmem_rdata    read beat k, valid in the k-th resp cycle; holds otherwise
//   pmem_err      one-cycle pulse on a protocol violation
module pmem_burst_responder #(
  parameter int DEPTH_BITS = 12,
  parameter int LATENCY    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic        pmem_resp,
  output logic [63:0] pmem_rdata,
  output logic        pmem_err
);

  localparam int         LINE_W    = DEPTH_BITS - 2;
  localparam logic [7:0] LAT_M1    = 8'(LATENCY - 1);
  localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

  state_t              r_state;
  logic                r_op_wr;
  logic [LINE_W-1:0]   r_line;
  logic [7:0]          r_cnt;
  logic [1:0]          r_beat;
  logic [63:0]         r_mem [2**DEPTH_BITS];

  logic [LINE_W-1:0]   w_addr_line;
  logic                w_req_live;
  logic [1:0]          w_beat_nxt;
  logic                w_we;
  logic                w_unused;

  assign w_addr_line = pmem_address[DEPTH_BITS+2:5];
  // Only the request line that was latched at acceptance matters afterwards.
  assign w_req_live  = r_op_wr ? pmem_write : pmem_read;
  assign w_beat_nxt  = r_beat + 2'd1;
  // A beat is stored only if the request is still held and reset is not
  // asserted at that edge; a dropped request suppresses the in-flight beat.
  assign w_we        = rst && (r_state == S_BURST) && r_op_wr && pmem_write;
  assign w_unused    = ^{pmem_address[31:DEPTH_BITS+3], pmem_address[4:0]};

  // Word array: no reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[{r_line, r_beat}] <= pmem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op_wr    <= 1'b0;
      r_line     <= '0;
      r_cnt      <= '0;
      r_beat     <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      pmem_err   <= 1'b0;
    end else begin
      pmem_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pmem_read && pmem_write) begin
            pmem_err <= 1'b1;
          end else if (pmem_read || pmem_write) begin
            r_op_wr <= pmem_write;
            r_line  <= w_addr_line;
            r_beat  <= '0;
            // With a latency of one the first beat follows acceptance directly.
            if (LATENCY == 1) begin
              r_cnt     <= '0;
              pmem_resp <= 1'b1;
              r_state   <= S_BURST;
              if (pmem_read) begin
                pmem_rdata <= r_mem[{w_addr_line, 2'b00}];
              end
            end else begin
              r_cnt   <= LAT_M1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!w_req_live) begin
            r_cnt    <= '0;
            pmem_err <= 1'b1;
            r_state  <= S_IDLE;
          end else if (r_cnt == 8'd1) begin
            // Counter reaches zero at this edge: first resp cycle follows.
            r_cnt     <= '0;
            r_beat    <= '0;
            pmem_resp <= 1'b1;
            r_state   <= S_BURST;
            if (!r_op_wr) begin
              pmem_rdata <= r_mem[{r_line, 2'b00}];
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_BURST: begin
          if (!w_req_live) begin
            r_beat    <= '0;
            pmem_resp <= 1'b0;
            pmem_err  <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_beat == LAST_BEAT) begin
            r_beat    <= '0;
            pmem_resp <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_beat <= w_beat_nxt;
            if (!r_op_wr) begin
              pmem_rdata <= r_mem[{r_line, w_beat_nxt}];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
module tb_pmem_burst_responder;

  localparam int DEPTH_BITS = 12;
  localparam int LATENCY    = 4;

  logic        clk;
  logic        rst;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;
  logic [63:0] pmem_rdata;
  logic        pmem_err;

  pmem_burst_responder #(
    .DEPTH_BITS (DEPTH_BITS),
    .LATENCY    (LATENCY),
    .BURST_LEN  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .pmem_err     (pmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: word index -> contents, only for words ever written.
  logic [63:0] mem_m [int];
  logic [63:0] last_rd;
  bit          last_known;
  logic [63:0] wbeat [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // First word index of the line: address modulo the array span, in words,
  // rounded down to a 4-word line.
  function automatic int line_base(input logic [31:0] addr);
    logic [31:0] span;
    span = 32'(1) << (DEPTH_BITS + 3);
    return int'((addr % span) / 32) * 4;
  endfunction

  // drop: 0..3 = lower request during that resp beat, 4 = complete normally,
  // -1 = lower request during the latency wait.
  task automatic txn(input bit wr, input logic [31:0] addr, input int drop);
    int base;
    base = line_base(addr);
    @(negedge clk);
    pmem_read    = !wr;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = {$urandom, $urandom};
    for (int c = 1; c < LATENCY; c++) begin
      @(negedge clk);
      check("wait_resp", 64'(pmem_resp), 64'd0);
      check("wait_err", 64'(pmem_err), 64'd0);
      if (drop < 0) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        check("wdrop_resp", 64'(pmem_resp), 64'd0);
        check("wdrop_err", 64'(pmem_err), 64'd1);
        @(negedge clk);
        check("wdrop_err_clr", 64'(pmem_err), 64'd0);
        return;
      end
      // Address and opposite line are don't-care after acceptance.
      pmem_address = $urandom;
      if (wr) pmem_read = 1'($urandom);
      else    pmem_write = 1'($urandom);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("beat_resp", 64'(pmem_resp), 64'd1);
      check("beat_err", 64'(pmem_err), 64'd0);
      if (wr) begin
        if (last_known) check("wr_rdata_hold", pmem_rdata, last_rd);
      end else begin
        if (mem_m.exists(base + k)) begin
          check("rd_beat", pmem_rdata, mem_m[base + k]);
          last_rd    = mem_m[base + k];
          last_known = 1'b1;
        end else begin
          last_known = 1'b0;
        end
      end
      if (k == drop) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        check("drop_resp", 64'(pmem_resp), 64'd0);
        check("drop_err", 64'(pmem_err), 64'd1);
        if (last_known) check("drop_rdata", pmem_rdata, last_rd);
        @(negedge clk);
        check("drop_err_clr", 64'(pmem_err), 64'd0);
        return;
      end
      if (wr) begin
        pmem_wdata       = wbeat[k];
        mem_m[base + k]  = wbeat[k];
      end
      pmem_address = $urandom;
      if (wr) pmem_read = 1'($urandom);
      else    pmem_write = 1'($urandom);
    end
    @(negedge clk);
    check("done_resp", 64'(pmem_resp), 64'd0);
    check("done_err", 64'(pmem_err), 64'd0);
    if (last_known) check("done_rdata", pmem_rdata, last_rd);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic rand_beats();
    for (int k = 0; k < 4; k++) wbeat[k] = {$urandom, $urandom};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    last_rd      = '0;
    last_known   = 1'b1;
    #23;
    check("rst_resp", 64'(pmem_resp), 64'd0);
    check("rst_rdata", pmem_rdata, 64'd0);
    check("rst_err", 64'(pmem_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Line write then reads, including aliased and unaligned addresses.
    wbeat[0] = 64'h1111111111111111;
    wbeat[1] = 64'h2222222222222222;
    wbeat[2] = 64'h3333333333333333;
    wbeat[3] = 64'h4444444444444444;
    txn(1'b1, 32'h100, 4);
    txn(1'b0, 32'h100, 4);
    check("read_last_beat", pmem_rdata, 64'h4444444444444444);
    txn(1'b0, 32'h8100, 4);
    txn(1'b0, 32'h104, 4);

    // Both request lines together: error pulse, no transfer.
    @(negedge clk);
    pmem_read  = 1'b1;
    pmem_write = 1'b1;
    pmem_address = 32'h100;
    @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    check("both_err", 64'(pmem_err), 64'd1);
    check("both_resp", 64'(pmem_resp), 64'd0);
    for (int i = 0; i < LATENCY + 4; i++) begin
      @(negedge clk);
      check("both_quiet_resp", 64'(pmem_resp), 64'd0);
      check("both_quiet_err", 64'(pmem_err), 64'd0);
    end
    txn(1'b0, 32'h100, 4);

    // Write aborted after two beats keeps beats 0-1 new, 2-3 old.
    rand_beats();
    txn(1'b1, 32'h200, 4);
    wbeat[0] = {2{32'hAAAAAAAA}};
    wbeat[1] = {2{32'hBBBBBBBB}};
    wbeat[2] = {2{32'hCCCCCCCC}};
    wbeat[3] = {2{32'hDDDDDDDD}};
    txn(1'b1, 32'h200, 2);
    txn(1'b0, 32'h200, 4);

    // Asynchronous reset in the wait phase of a read.
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 32'h100;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_resp", 64'(pmem_resp), 64'd0);
    check("arst_rdata", pmem_rdata, 64'd0);
    check("arst_err", 64'(pmem_err), 64'd0);
    @(negedge clk);
    pmem_read = 1'b0;
    rst       = 1'b1;
    last_rd   = '0;
    last_known = 1'b1;
    txn(1'b0, 32'h100, 4);

    // Drops in the wait phase and mid read burst.
    txn(1'b0, 32'h100, -1);
    txn(1'b0, 32'h100, 1);

    // Randomized traffic over a small pool of lines with aliasing bits.
    for (int l = 8; l <= 16; l++) begin
      rand_beats();
      txn(1'b1, 32'(l) << 5, 4);
    end
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          d;
      bit          wr;
      a  = (32'($urandom_range(8, 16)) << 5) | 32'($urandom_range(0, 31))
         | (32'($urandom_range(0, 15)) << (DEPTH_BITS + 3));
      wr = 1'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 4;
      if ($urandom_range(0, 19) == 0) d = -1;
      rand_beats();
      txn(wr, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
